// File: rtl/seq_restoring_divider.sv
// seq_restoring_divider: iterative restoring divider, one quotient bit per clock with valid/ready handshakes
module seq_restoring_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  busy
);
  localparam int CW = DIVIDEND_W > 1 ? $clog2(DIVIDEND_W) : 1;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state, state_n;
  logic [DIVIDEND_W-1:0] sh, sh_n;
  logic [DIVISOR_W-1:0]  r, r_n, dvs;
  logic [DIVISOR_W:0]    r_sh;
  logic [CW-1:0]         cnt;
  logic                  ge, accept;
  assign in_ready  = state == IDLE;
  assign out_valid = state == DONE;
  assign busy      = state == CALC;
  // R stays below the divisor, so only its low DIVISOR_W bits need storing
  always_comb begin
    accept  = in_valid && state == IDLE;
    r_sh    = {r, sh[DIVIDEND_W-1]};
    ge      = r_sh >= {1'b0, dvs};
    r_n     = ge ? DIVISOR_W'(r_sh - {1'b0, dvs}) : r_sh[DIVISOR_W-1:0];
    sh_n    = {sh[DIVIDEND_W-2:0], ge};
    state_n = state == IDLE ? (in_valid ? (divisor == '0 ? DONE : CALC) : IDLE)
            : state == CALC ? (cnt == '0 ? DONE : CALC)
            : (out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge clk)
    if (rst) begin
      sh          <= '0;
      r           <= '0;
      dvs         <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      sh          <= dividend;
      dvs         <= divisor;
      r           <= '0;
      cnt         <= CW'(DIVIDEND_W - 1);
      div_by_zero <= divisor == '0;
      if (divisor == '0) begin
        quotient  <= '1;
        remainder <= dividend[DIVISOR_W-1:0];
      end
    end else if (state == CALC) begin
      sh  <= sh_n;
      r   <= r_n;
      cnt <= cnt - 1'b1;
      if (cnt == '0) begin
        quotient  <= sh_n;
        remainder <= r_n;
      end
    end
endmodule
